spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 32 +++
 rtl/spi_slave.sv | 178 +++++++++++++++++
 tb/tb_spi_slave.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave pin and host-side handshake bundle.
`timescale 1ns/1ps

interface spi_slave_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  // Serial side, driven by the SPI master
  logic                  spi_clk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;

  // Host side, toward the local system
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  overrun;
  logic                  frame_err;

  modport slave (
    input  spi_clk, cs, mosi, tx_data, rx_ack,
    output miso, miso_oe, tx_load, data_rd, rx_valid, overrun, frame_err
  );

  modport master (
    output spi_clk, cs, mosi, tx_data, rx_ack,
    input  miso, miso_oe, tx_load, data_rd, rx_valid, overrun, frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, MSB first, oversampled by clk.
// spi_clk/cs/mosi are synchronized into the clk domain and edge-detected;
// spi_clk must run at clk/8 or slower. DATA_WIDTH must not exceed 15
// (4-bit bit counter) and SYNC_STAGES must be at least 2.
`timescale 1ns/1ps

module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       polarity,
  input  logic       phase,
  spi_slave_if.slave bus,
  output logic [1:0] state,
  output logic [3:0] count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] CNT_FULL = 4'(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;

  logic cpol, cpha;

  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] data_rd_r;

  logic miso_oe_r;
  logic tx_load_r;
  logic rx_valid_r;
  logic overrun_r;
  logic frame_err_r;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one-cycle-delayed copies for edge detection.
  // cs resets to 0 (asserted) so a cs that is already low at reset release
  // never looks like a falling edge; a fresh high-to-low toggle is required.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Edge classification for the mode latched at the start of the frame
  always_comb begin
    sclk_rise   = sclk_s & ~sclk_d;
    sclk_fall   = ~sclk_s & sclk_d;
    cs_rise     = cs_s & ~cs_d;
    cs_fall     = ~cs_s & cs_d;
    lead_edge   = ~cs_s & (cpol ? sclk_fall : sclk_rise);
    trail_edge  = ~cs_s & (cpol ? sclk_rise : sclk_fall);
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
  end

  // Frame control FSM with transmit/receive shift registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= CNT_FULL;
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      miso_oe_r   <= 1'b0;
      tx_load_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      tx_load_r   <= 1'b0;
      frame_err_r <= 1'b0;
      if (cs_rise) begin
        if (count != CNT_FULL && count != 4'd0) begin
          frame_err_r <= 1'b1;
        end
        state     <= S_IDLE;
        count     <= CNT_FULL;
        tx_sr     <= '0;
        rx_sr     <= '0;
        miso_oe_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state     <= S_ACTIVE;
              cpol      <= polarity;
              cpha      <= phase;
              count     <= CNT_FULL;
              tx_sr     <= bus.tx_data;
              rx_sr     <= '0;
              tx_load_r <= 1'b1;
              miso_oe_r <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (sample_edge) begin
              rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
              count <= count - 4'd1;
              if (count == 4'd1) begin
                state <= S_DONE;
              end
            end else if (shift_edge && count != CNT_FULL) begin
              // A shift edge before any bit of this byte was sampled belongs
              // to the previous byte (CPHA=0) or is the edge that presents
              // the MSB (CPHA=1); either way the freshly loaded MSB must stay.
              tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end
          end
          S_DONE: begin
            state     <= S_ACTIVE;
            count     <= CNT_FULL;
            tx_sr     <= bus.tx_data;
            tx_load_r <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            count <= CNT_FULL;
          end
        endcase
      end
    end
  end

  // Host handoff: publish completed bytes, track acknowledge and overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_rd_r  <= '0;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (state == S_DONE) begin
        data_rd_r  <= rx_sr;
        rx_valid_r <= 1'b1;
        overrun_r  <= rx_valid_r & ~bus.rx_ack;
      end else if (bus.rx_ack && rx_valid_r) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign bus.miso      = miso_oe_r ? tx_sr[DATA_WIDTH-1] : 1'b1;
  assign bus.miso_oe   = miso_oe_r;
  assign bus.tx_load   = tx_load_r;
  assign bus.data_rd   = data_rd_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bus-functional SPI master drives frames,
// received bytes are queued as they are sent and checked as they land.
`timescale 1ns/1ps

module tb_spi_slave;

  localparam int unsigned HALF = 8;  // spi_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       polarity;
  logic       phase;
  logic [1:0] state;
  logic [3:0] count;

  spi_slave_if #(.DATA_WIDTH(8)) bus ();

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .phase    (phase),
    .bus      (bus),
    .state    (state),
    .count    (count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  sb[$];
  logic [7:0]  exp_b;
  logic        cmp_pending = 1'b0;
  logic        ack_on_done = 1'b0;
  int unsigned ack_req     = 0;
  int unsigned ack_served  = 0;
  int unsigned n_load      = 0;
  int unsigned n_ovr       = 0;
  int unsigned n_ferr      = 0;
  int unsigned n_done      = 0;
  int unsigned load_snap   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pulse counters, rx_ack driver, scoreboard pop on completion
  always @(negedge clk) begin
    bus.rx_ack = 1'b0;
    if (bus.tx_load)   n_load++;
    if (bus.overrun)   n_ovr++;
    if (bus.frame_err) n_ferr++;
    if (cmp_pending) begin
      cmp_pending = 1'b0;
      if (sb.size() == 0) begin
        check_eq("sb_pop", 32'(sb.size()), 32'd1);
      end else begin
        exp_b = sb.pop_front();
        check_eq("data_rd", 32'(bus.data_rd), 32'(exp_b));
      end
    end
    if (state == 2'd2) begin
      cmp_pending = 1'b1;
      n_done++;
      load_snap = n_load;
      if (ack_on_done) bus.rx_ack = 1'b1;
    end
    if (ack_served != ack_req) begin
      ack_served++;
      bus.rx_ack = 1'b1;
    end
  end

  task automatic set_mode(input logic [1:0] m);
    polarity    = m[1];
    phase       = m[0];
    bus.spi_clk = m[1];
    wait_clks(4);
  endtask

  // Master shifts nbits of mo out (MSB first) and collects miso into mi
  task automatic spi_bits(input logic [7:0] mo, input int unsigned nbits, output logic [7:0] mi);
    mi = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      if (!phase) begin
        bus.mosi = mo[3'(7 - i)];
        wait_clks(HALF);
        mi = {mi[6:0], bus.miso};
        bus.spi_clk = ~bus.spi_clk;
        wait_clks(HALF);
        bus.spi_clk = ~bus.spi_clk;
      end else begin
        bus.spi_clk = ~bus.spi_clk;
        bus.mosi    = mo[3'(7 - i)];
        wait_clks(HALF);
        mi = {mi[6:0], bus.miso};
        bus.spi_clk = ~bus.spi_clk;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] tx_exp);
    logic [7:0] got;
    sb.push_back(mo);
    spi_bits(mo, 8, got);
    check_eq("miso_byte", 32'(got), 32'(tx_exp));
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    bus.cs = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic ack();
    ack_req++;
    wait_clks(3);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"},     32'(state),         32'd0);
    check_eq({tag, "_count"},     32'(count),         32'd8);
    check_eq({tag, "_miso"},      32'(bus.miso),      32'd1);
    check_eq({tag, "_miso_oe"},   32'(bus.miso_oe),   32'd0);
    check_eq({tag, "_data_rd"},   32'(bus.data_rd),   32'd0);
    check_eq({tag, "_rx_valid"},  32'(bus.rx_valid),  32'd0);
    check_eq({tag, "_tx_load"},   32'(bus.tx_load),   32'd0);
    check_eq({tag, "_overrun"},   32'(bus.overrun),   32'd0);
    check_eq({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    int unsigned l0, o0, f0, d0;
    logic [7:0]  got;

    reset       = 1'b0;
    polarity    = 1'b0;
    phase       = 1'b0;
    bus.spi_clk = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'hA5;
    wait_clks(3);
    check_reset_values("por");
    reset = 1'b1;
    wait_clks(4);

    // All four modes: return 0xA5 while receiving 0x3C
    for (int unsigned m = 0; m < 4; m++) begin
      set_mode(2'(m));
      l0 = n_load;
      cs_low();
      send_byte(8'h3C, 8'hA5);
      cs_high();
      check_eq("mode_rx_valid", 32'(bus.rx_valid), 32'd1);
      check_eq("mode_tx_load",  load_snap - l0,    32'd1);
      check_eq("mode_oe_off",   32'(bus.miso_oe),  32'd0);
      check_eq("mode_state",    32'(state),        32'd0);
      ack();
      check_eq("ack_clears",    32'(bus.rx_valid), 32'd0);
    end
    ack();
    check_eq("ack_idle_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("ack_idle_data",  32'(bus.data_rd),  32'h3C);
    check_eq("no_overrun",     n_ovr,             32'd0);
    check_eq("no_frame_err",   n_ferr,            32'd0);

    // Back-to-back two-byte frame without acknowledge
    set_mode(2'd0);
    l0 = n_load;
    o0 = n_ovr;
    cs_low();
    send_byte(8'h12, 8'hA5);
    send_byte(8'h34, 8'hA5);
    cs_high();
    check_eq("two_overrun",  n_ovr - o0,        32'd1);
    // loads up to the second completion; the reload that follows it is for
    // a byte the master never clocks out
    check_eq("two_tx_load",  load_snap - l0,    32'd2);
    check_eq("two_rx_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("two_data_rd",  32'(bus.data_rd),  32'h34);

    // cs released after five bits
    f0 = n_ferr;
    cs_low();
    spi_bits(8'hF0, 5, got);
    cs_high();
    check_eq("ferr_pulse",    n_ferr - f0,       32'd1);
    check_eq("ferr_oe",       32'(bus.miso_oe),  32'd0);
    check_eq("ferr_data_rd",  32'(bus.data_rd),  32'h34);
    check_eq("ferr_rx_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("ferr_state",    32'(state),        32'd0);
    check_eq("ferr_count",    32'(count),        32'd8);

    // Acknowledge landing in the completion cycle of 0x55
    o0 = n_ovr;
    ack_on_done = 1'b1;
    cs_low();
    send_byte(8'h55, 8'hA5);
    cs_high();
    ack_on_done = 1'b0;
    check_eq("ackdone_rx_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("ackdone_data_rd",  32'(bus.data_rd),  32'h55);
    check_eq("ackdone_overrun",  n_ovr - o0,        32'd0);

    // Reset after three bits, released with cs still low
    cs_low();
    spi_bits(8'hC3, 3, got);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    wait_clks(2);
    reset = 1'b1;
    wait_clks(4);
    d0 = n_done;
    spi_bits(8'hC3, 5, got);
    wait_clks(HALF);
    check_eq("rst_ignored_done",  n_done - d0,       32'd0);
    check_eq("rst_ignored_state", 32'(state),        32'd0);
    check_eq("rst_ignored_oe",    32'(bus.miso_oe),  32'd0);
    check_eq("rst_ignored_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_ignored_data",  32'(bus.data_rd),  32'd0);
    bus.cs = 1'b1;
    wait_clks(2 * HALF);

    // Fresh frame after cs toggled
    bus.tx_data = 8'h5A;
    cs_low();
    send_byte(8'h96, 8'h5A);
    cs_high();
    check_eq("post_rst_valid", 32'(bus.rx_valid), 32'd1);

    wait_clks(4);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
